// File: rtl/ps2_receptor.sv
// PS/2 keyboard receiver: synchronise, deglitch, deserialise and check
// 11-bit frames, publishing one scancode strobe per good frame.
module ps2_receptor #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clock_fpga,
    input  logic        reset,
    input  logic        clock_intermediar,
    input  logic        data_in,
    output logic [10:0] data_in_parallel,
    output logic [3:0]  count,
    output logic [7:0]  scancode,
    output logic        code_valid,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic [FW-1:0]          filt_cnt;
    logic                   clk_f;
    logic                   clk_f_q;
    logic                   fall;
    logic [TW-1:0]          tcnt;
    logic                   clk_s;
    logic                   dat_s;
    logic                   frame_ok;

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];

    assign frame_ok = (data_in_parallel[0] == 1'b0) &&
                      (data_in_parallel[10] == 1'b1) &&
                      (^data_in_parallel[9:1] == 1'b1);

    // Bring the asynchronous keyboard lines into the clock_fpga domain
    always_ff @(posedge clock_fpga or negedge reset) begin
        if (!reset) begin
            clk_sync <= '0;
            dat_sync <= '0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], clock_intermediar};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], data_in};
        end
    end

    // Deglitch the PS/2 clock: change only after a run of equal samples
    always_ff @(posedge clock_fpga or negedge reset) begin
        if (!reset) begin
            filt_cnt <= '0;
            clk_f    <= 1'b0;
        end else if (clk_s == clk_f) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_f    <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // One-cycle registered pulse on each falling edge of the filtered clock
    always_ff @(posedge clock_fpga or negedge reset) begin
        if (!reset) begin
            clk_f_q <= 1'b0;
            fall    <= 1'b0;
        end else begin
            clk_f_q <= clk_f;
            fall    <= clk_f_q & ~clk_f;
        end
    end

    // Frame FSM: collect bits, watch for stalls, check and publish
    always_ff @(posedge clock_fpga or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            data_in_parallel <= '0;
            count            <= '0;
            scancode         <= '0;
            code_valid       <= 1'b0;
            frame_err        <= 1'b0;
            tcnt             <= '0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (fall && !dat_s) begin
                        data_in_parallel <= '0;
                        count            <= 4'd1;
                        state            <= RECV;
                    end
                end
                RECV: begin
                    if (fall) begin
                        tcnt                    <= '0;
                        data_in_parallel[count] <= dat_s;
                        count                   <= count + 4'd1;
                        if (count == 4'd10) begin
                            state <= DONE;
                        end
                    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        frame_err        <= 1'b1;
                        count            <= '0;
                        data_in_parallel <= '0;
                        tcnt             <= '0;
                        state            <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: begin
                    if (frame_ok) begin
                        scancode   <= data_in_parallel[8:1];
                        code_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    count <= '0;
                    tcnt  <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_receptor.sv
// Directed vector bench for ps2_receptor: frame table plus hand-written
// glitch, timeout and mid-frame reset sequences.
module tb_ps2_receptor;

    localparam int TMO = 300;

    logic        clk;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [10:0] data_in_parallel;
    logic [3:0]  count;
    logic [7:0]  scancode;
    logic        code_valid;
    logic        frame_err;

    int n_vec;
    int n_fail;
    int n_valid;
    int n_err;
    logic [7:0] got[$];

    typedef struct {
        logic [10:0] frame;
        int          exp_valid;
        int          exp_err;
        logic [7:0]  exp_code;
    } vec_t;

    vec_t tbl[7];

    ps2_receptor #(
        .SYNC_STAGES(2),
        .FILTER_LEN(4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock_fpga(clk),
        .reset(rst_n),
        .clock_intermediar(ps2_clk),
        .data_in(ps2_dat),
        .data_in_parallel(data_in_parallel),
        .count(count),
        .scancode(scancode),
        .code_valid(code_valid),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (code_valid) begin
            n_valid = n_valid + 1;
            got.push_back(scancode);
        end
        if (frame_err) n_err = n_err + 1;
        if (code_valid && frame_err) begin
            n_fail = n_fail + 1;
            $display("FAIL strobe_excl: code_valid and frame_err both 1");
        end
    end

    function automatic logic [10:0] mk(logic [7:0] d, logic par, logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int exp_cnt);
        ps2_dat = b;
        repeat (10) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        if (exp_cnt >= 0) chk("count_step", 32'(count), 32'(exp_cnt));
        ps2_clk = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            send_bit(f[i], (i == 10) ? 0 : i + 1);
        end
    endtask

    task automatic glitch();
        @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int v0;
        int e0;
        int q0;
        n_vec   = 0;
        n_fail  = 0;
        n_valid = 0;
        n_err   = 0;

        tbl[0] = '{mk(8'h1C, 1'b0, 1'b1), 1, 0, 8'h1C};
        tbl[1] = '{mk(8'h1C, 1'b1, 1'b1), 0, 1, 8'h1C};
        tbl[2] = '{mk(8'h1C, 1'b0, 1'b0), 0, 1, 8'h1C};
        tbl[3] = '{mk(8'hF0, 1'b1, 1'b1), 1, 0, 8'hF0};
        tbl[4] = '{mk(8'h00, 1'b1, 1'b1), 1, 0, 8'h00};
        tbl[5] = '{mk(8'hA5, 1'b1, 1'b1), 1, 0, 8'hA5};
        tbl[6] = '{mk(8'hA5, 1'b0, 1'b1), 0, 1, 8'hA5};

        rst_n   = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_frame", 32'(data_in_parallel), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_code", 32'(scancode), 32'h0);
        chk("rst_valid", 32'(code_valid), 32'h0);
        chk("rst_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        for (int k = 0; k < 7; k++) begin
            v0 = n_valid;
            e0 = n_err;
            send_bits(tbl[k].frame, 0, 10);
            repeat (20) @(posedge clk);
            @(negedge clk);
            chk("vec_valid", 32'(n_valid - v0), 32'(tbl[k].exp_valid));
            chk("vec_err", 32'(n_err - e0), 32'(tbl[k].exp_err));
            chk("vec_code", 32'(scancode), 32'(tbl[k].exp_code));
            chk("vec_frame", 32'(data_in_parallel), 32'(tbl[k].frame));
            chk("vec_count", 32'(count), 32'h0);
        end

        v0 = n_valid;
        e0 = n_err;
        send_bits(mk(8'hF0, 1'b1, 1'b1), 0, 4);
        repeat (TMO + 100) @(posedge clk);
        @(negedge clk);
        chk("tmo_err", 32'(n_err - e0), 32'h1);
        chk("tmo_valid", 32'(n_valid - v0), 32'h0);
        chk("tmo_count", 32'(count), 32'h0);
        chk("tmo_frame", 32'(data_in_parallel), 32'h0);
        send_bits(mk(8'h1C, 1'b0, 1'b1), 0, 10);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("tmo_next_valid", 32'(n_valid - v0), 32'h1);
        chk("tmo_next_code", 32'(scancode), 32'h1C);

        v0 = n_valid;
        e0 = n_err;
        glitch();
        chk("gl_idle_count", 32'(count), 32'h0);
        chk("gl_idle_strb", 32'(n_valid + n_err - v0 - e0), 32'h0);
        send_bits(mk(8'h5A, 1'b1, 1'b1), 0, 2);
        glitch();
        chk("gl_recv_count", 32'(count), 32'h3);
        chk("gl_recv_strb", 32'(n_valid + n_err - v0 - e0), 32'h0);
        send_bits(mk(8'h5A, 1'b1, 1'b1), 3, 10);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("gl_recv_valid", 32'(n_valid - v0), 32'h1);
        chk("gl_recv_code", 32'(scancode), 32'h5A);

        send_bits(mk(8'hF0, 1'b1, 1'b1), 0, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_frame", 32'(data_in_parallel), 32'h0);
        chk("mid_rst_count", 32'(count), 32'h0);
        chk("mid_rst_code", 32'(scancode), 32'h0);
        chk("mid_rst_valid", 32'(code_valid), 32'h0);
        chk("mid_rst_err", 32'(frame_err), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        v0 = n_valid;
        e0 = n_err;
        q0 = got.size();
        send_bits(mk(8'hF0, 1'b1, 1'b1), 0, 10);
        send_bits(mk(8'h1C, 1'b0, 1'b1), 0, 10);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("b2b_valid", 32'(n_valid - v0), 32'h2);
        chk("b2b_err", 32'(n_err - e0), 32'h0);
        if (got.size() >= q0 + 2) begin
            chk("b2b_first", 32'(got[q0]), 32'hF0);
            chk("b2b_second", 32'(got[q0+1]), 32'h1C);
        end else begin
            n_vec  = n_vec + 1;
            n_fail = n_fail + 1;
            $display("FAIL b2b_order: got %0d codes expected 2", got.size() - q0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
